// File: rtl/alu_issue_q.sv
// Operand issue queue and registered result stage wrapped around a combinational alu.
// Optional feature macro: ALU_ISSUE_Q_OVF_CNT_EN (retired-overflow counter on ovf_cnt).
module alu_issue_q #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_a,
  input  logic [XLEN-1:0]            in_b,
  input  logic [3:0]                 in_op,
  output logic [XLEN-1:0]            alu_a,
  output logic [XLEN-1:0]            alu_b,
  output logic [3:0]                 alu_op,
  input  logic [XLEN-1:0]            alu_r,
  input  logic                       alu_z,
  input  logic                       alu_v,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_r,
  output logic                       out_z,
  output logic                       out_v,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [15:0]                ovf_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ZERO  = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [XLEN-1:0] DAT_ZERO = {XLEN{1'b0}};

  logic [3:0]      op_mem_q [DEPTH];
  logic [3:0]      op_mem_d [DEPTH];
  logic [XLEN-1:0] a_mem_q  [DEPTH];
  logic [XLEN-1:0] a_mem_d  [DEPTH];
  logic [XLEN-1:0] b_mem_q  [DEPTH];
  logic [XLEN-1:0] b_mem_d  [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_r_q, out_r_d;
  logic            out_z_q, out_z_d;
  logic            out_v_q, out_v_d;

  logic            push_s;
  logic            pop_s;
  logic            not_empty_s;

  assign not_empty_s = (level_q != LVL_ZERO);
  assign in_ready    = (level_q != FULL_LVL);
  // flush outranks both handshakes, so a request in a flush cycle is dropped
  assign push_s      = in_valid && in_ready && !flush;
  assign pop_s       = not_empty_s && (!out_valid_q || out_ready) && !flush;

  // Head entry drives the alu; zeros when the queue is empty.
  always_comb begin
    alu_a  = DAT_ZERO;
    alu_b  = DAT_ZERO;
    alu_op = 4'h0;
    if (not_empty_s) begin
      alu_a  = a_mem_q[rd_ptr_q];
      alu_b  = b_mem_q[rd_ptr_q];
      alu_op = op_mem_q[rd_ptr_q];
    end else begin
      alu_a  = DAT_ZERO;
      alu_b  = DAT_ZERO;
      alu_op = 4'h0;
    end
  end

  // Storage write at the write pointer on an accepted push.
  always_comb begin
    op_mem_d = op_mem_q;
    a_mem_d  = a_mem_q;
    b_mem_d  = b_mem_q;
    if (push_s) begin
      op_mem_d[wr_ptr_q] = in_op;
      a_mem_d[wr_ptr_q]  = in_a;
      b_mem_d[wr_ptr_q]  = in_b;
    end else begin
      op_mem_d[wr_ptr_q] = op_mem_q[wr_ptr_q];
      a_mem_d[wr_ptr_q]  = a_mem_q[wr_ptr_q];
      b_mem_d[wr_ptr_q]  = b_mem_q[wr_ptr_q];
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      level_d  = LVL_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // Result register: load on issue, drop valid when drained, hold while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_z_d     = out_z_q;
    out_v_d     = out_v_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_r_d     = DAT_ZERO;
      out_z_d     = 1'b0;
      out_v_d     = 1'b0;
    end else if (pop_s) begin
      out_valid_d = 1'b1;
      out_r_d     = alu_r;
      out_z_d     = alu_z;
      out_v_d     = alu_v;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Queue storage flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_mem_q[i] <= 4'h0;
        a_mem_q[i]  <= DAT_ZERO;
        b_mem_q[i]  <= DAT_ZERO;
      end
    end else begin
      op_mem_q <= op_mem_d;
      a_mem_q  <= a_mem_d;
      b_mem_q  <= b_mem_d;
    end
  end

  // Control and result flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      level_q     <= LVL_ZERO;
      out_valid_q <= 1'b0;
      out_r_q     <= DAT_ZERO;
      out_z_q     <= 1'b0;
      out_v_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_z_q     <= out_z_d;
      out_v_q     <= out_v_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_z     = out_z_q;
  assign out_v     = out_v_q;
  assign level     = level_q;

`ifdef ALU_ISSUE_Q_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating count of retired overflowing results; survives flush.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (out_valid_q && out_ready && out_v_q && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'h0001;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Overflow counter flop, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt_q <= 16'h0000;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  assign ovf_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_issue_q.sv
// Directed scoreboard bench for alu_issue_q with an adder/overflow alu model.
module tb_alu_issue_q;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_a, in_b;
  logic [3:0]      in_op;
  logic [XLEN-1:0] alu_a, alu_b, alu_r;
  logic [3:0]      alu_op;
  logic            alu_z, alu_v;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_r;
  logic            out_z, out_v;
  logic [2:0]      level;
  logic [15:0]     ovf_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [XLEN+1:0] sb [$];
  logic [15:0] exp_ovf;

  alu_issue_q #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_z(alu_z), .alu_v(alu_v),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_z(out_z), .out_v(out_v),
    .level(level), .ovf_cnt(ovf_cnt)
  );

  // alu model attached to the head-presentation ports
  assign alu_r = alu_a + alu_b;
  assign alu_z = (alu_r == 32'h0);
  assign alu_v = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [XLEN+1:0] model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = a + b;
    return {r, (r == 32'h0), ((a[31] == b[31]) && (r[31] != a[31]))};
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock: score the output handshake, record accepted requests, check stall stability.
  task automatic cycle();
    logic            stall;
    logic [XLEN-1:0] held_r;
    logic [XLEN+1:0] exp;
    if (out_valid && out_ready) begin
      if (sb.size() > 0) exp = sb.pop_front();
      else               exp = ~{out_r, out_z, out_v};
      chk("result", {62'h0, out_r, out_z, out_v}, {62'h0, exp});
    end
    if (in_valid && in_ready && !flush && rst) sb.push_back(model(in_a, in_b));
    stall  = out_valid && !out_ready && !flush && rst;
    held_r = out_r;
    @(posedge clk); #1;
    if (stall && rst) begin
      chk("stall_valid", {63'h0, out_valid}, 64'h1);
      chk("stall_r", {32'h0, out_r}, {32'h0, held_r});
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_empty", sb.size(), 64'h0);
  endtask

  initial begin
    int i, t, n;
    logic acc;
`ifdef ALU_ISSUE_Q_OVF_CNT_EN
    exp_ovf = 16'd3;
`else
    exp_ovf = 16'd0;
`endif
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 4'h0; out_ready = 1'b0;
    #3;
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_out_r", {32'h0, out_r}, 64'h0);
    chk("rst_level", {61'h0, level}, 64'h0);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_alu_a", {32'h0, alu_a}, 64'h0);
    chk("rst_ovf", {48'h0, ovf_cnt}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    cycle();

    // single request: 3 + (-3)
    out_ready = 1'b1; in_valid = 1'b1; in_a = 32'd3; in_b = 32'hFFFF_FFFD; in_op = 4'h1;
    cycle();
    in_valid = 1'b0;
    chk("single_level", {61'h0, level}, 64'h1);
    chk("single_nolat", {63'h0, out_valid}, 64'h0);
    chk("single_alu_a", {32'h0, alu_a}, 64'h3);
    chk("single_alu_op", {60'h0, alu_op}, 64'h1);
    cycle();
    chk("single_valid", {63'h0, out_valid}, 64'h1);
    chk("single_r", {32'h0, out_r}, 64'h0);
    chk("single_z", {63'h0, out_z}, 64'h1);
    chk("single_v", {63'h0, out_v}, 64'h0);
    cycle();
    chk("single_retired", {63'h0, out_valid}, 64'h0);

    // fill: 1 into the output register, 4 into the FIFO, 6th stalls
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_a = 32'd100 + k; in_b = 32'd7 * k; in_op = 4'(k);
      cycle();
    end
    chk("fill_level", {61'h0, level}, 64'h4);
    chk("fill_in_ready", {63'h0, in_ready}, 64'h0);
    chk("fill_out_valid", {63'h0, out_valid}, 64'h1);
    in_a = 32'd999; in_b = 32'd1;
    cycle();
    chk("fill_stall_level", {61'h0, level}, 64'h4);
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      cycle();
      n++;
    end
    chk("fill_drain_cycles", n, 64'h5);
    chk("fill_done_valid", {63'h0, out_valid}, 64'h0);

    // backpressure: 16 pushes of a=b=i with out_ready toggling
    i = 0; t = 0;
    while (i < 16 && t < 200) begin
      in_valid = 1'b1; in_a = i; in_b = i; in_op = 4'h2;
      out_ready = t[0];
      acc = in_ready;
      cycle();
      if (acc) i++;
      t++;
    end
    chk("bp_pushed", i, 64'd16);
    in_valid = 1'b0; out_ready = 1'b1;
    drain(50);

    // overflow accounting
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_a = (k < 3) ? 32'h7FFF_FFFF : 32'h1;
      in_b = 32'h1;
      cycle();
    end
    in_valid = 1'b0;
    drain(50);
    cycle();
    chk("ovf_cnt", {48'h0, ovf_cnt}, {48'h0, exp_ovf});

    // flush with a simultaneous request
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_a = 32'd20 + k; in_b = 32'd1;
      cycle();
    end
    chk("pre_flush_level", {61'h0, level}, 64'h2);
    chk("pre_flush_valid", {63'h0, out_valid}, 64'h1);
    flush = 1'b1; in_valid = 1'b1; in_a = 32'd99; in_b = 32'd1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    chk("flush_level", {61'h0, level}, 64'h0);
    chk("flush_valid", {63'h0, out_valid}, 64'h0);
    chk("flush_r", {32'h0, out_r}, 64'h0);
    chk("flush_keeps_ovf", {48'h0, ovf_cnt}, {48'h0, exp_ovf});
    cycle();
    chk("flush_dropped", {61'h0, level}, 64'h0);

    // asynchronous reset mid-stream
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_a = 32'd40 + k; in_b = 32'd2;
      cycle();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    chk("arst_valid", {63'h0, out_valid}, 64'h0);
    chk("arst_level", {61'h0, level}, 64'h0);
    chk("arst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("arst_alu_a", {32'h0, alu_a}, 64'h0);
    chk("arst_r", {32'h0, out_r}, 64'h0);
    chk("arst_ovf", {48'h0, ovf_cnt}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    cycle();
    cycle();
    chk("post_rst_level", {61'h0, level}, 64'h0);
    chk("post_rst_valid", {63'h0, out_valid}, 64'h0);

    // sanity transaction after reset
    out_ready = 1'b1; in_valid = 1'b1; in_a = 32'd5; in_b = 32'd6;
    cycle();
    in_valid = 1'b0;
    drain(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue_q.md
# alu_issue_q

Operand issue queue and result stage placed directly around the `alu` execute unit. It accepts {op, a, b} requests on a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It presents the head entry to the combinational `alu`, then captures `r`/`z`/`v` into an output register with its own valid/ready handshake. This decouples the operand producer from the result consumer at one result per clock.

## Interface
- `XLEN`, 32: operand/result width; must match the attached `alu`.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted when 0).
- `flush` in 1: synchronous clear of FIFO and output register.
- `in_valid` in 1: request valid.
- `in_ready` out 1: queue can accept.
- `in_a`, `in_b` in XLEN: operands.
- `in_op` in 4: operation code; opaque to this block.
- `alu_a`, `alu_b` out XLEN: to `alu` a/b.
- `alu_op` out 4: to `alu` op.
- `alu_r` in XLEN: from `alu` r.
- `alu_z`, `alu_v` in 1: from `alu` z/v.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts.
- `out_r` out XLEN: registered result.
- `out_z`, `out_v` out 1: registered flags.
- `level` out $clog2(DEPTH+1): FIFO occupancy.
- `ovf_cnt` out 16: count of retired results with v=1; see Configuration.

## Operation
- Push when `in_valid && in_ready`: entry {in_op, in_a, in_b} written at the write pointer.
- `in_ready = (level != DEPTH)`. There is no push-through-when-full, even if a pop happens the same cycle.
- Head presentation: when `level != 0`, `alu_a`/`alu_b`/`alu_op` are driven combinationally from the head entry. When the FIFO is empty they are driven to 0.
- Issue (pop) fires when `level != 0 && (!out_valid || out_ready)`:
  - `out_r`/`out_z`/`out_v` load `alu_r`/`alu_z`/`alu_v`.
  - `out_valid` is set to 1.
  - The read pointer advances.
- `out_valid` clears when `out_ready && out_valid` and no issue occurs that cycle.
- Output register holds stable while `out_valid && !out_ready`.
- Simultaneous push and pop (FIFO neither empty nor full): `level` is unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- `flush` takes priority over push and issue. The next edge sets:
  - `level` = 0 and both pointers = 0.
  - `out_valid` = 0 and `out_r`/`out_z`/`out_v` = 0.
- Requests presented during a flush cycle are dropped, even if `in_ready` = 1.
- Results are issued strictly in acceptance order, with no reordering.

## Timing
- Reset values:
  - `out_valid` = 0, `out_r` = 0, `out_z` = 0, `out_v` = 0.
  - `level` = 0, `ovf_cnt` = 0.
  - `alu_*` = 0 and `in_ready` = 1.
- Reset is asynchronous on assertion; deassertion is sampled at the next rising `clk`.
- Reset mid-operation discards all queued and held results.
- Latency: a request accepted at edge N appears as `out_valid` = 1 after edge N+1, provided the queue was empty and the output register was free or drained.
- Throughput: 1 result/cycle while `out_ready` = 1 and `in_valid` = 1.
- `alu` is combinational. The path from head entry through `alu` to the output register is single-cycle.

## Configuration
- `ALU_ISSUE_Q_OVF_CNT_EN` defined:
  - `ovf_cnt` increments by 1 on each output handshake (`out_valid && out_ready`) with `out_v` = 1.
  - It saturates at 0xFFFF.
  - It is cleared only by reset; `flush` does not clear it.
- Not defined: `ovf_cnt` is tied to 0 and no counter logic is synthesized.

## Test plan
Bench `alu` model: r=a+b, z=(r==0), v=signed overflow.
- Single request: reset, then push a=3, b=-3 with `out_ready` = 1 → one cycle after the accept edge, `out_valid` = 1, `out_r` = 0, `out_z` = 1, `out_v` = 0.
- Fill: `out_ready` = 0, push 5 requests with DEPTH=4 → the 1st retires into the output register. The next 4 fill the FIFO (`level` = 4, `in_ready` = 0), so the 6th push stalls. Raise `out_ready` → results appear in push order, one per cycle.
- Backpressure: toggle `out_ready` every other cycle over 16 pushes (a=i, b=i) → `out_r` equals 2i for all entries in order, no loss or duplication, and `out_r` stable while stalled.
- Overflow count with `ALU_ISSUE_Q_OVF_CNT_EN`: push a=0x7FFFFFFF, b=1 three times, then a=1, b=1 → `out_v` = 1 on the first three results, and `ovf_cnt` = 3 after all four drain. Without the macro, `ovf_cnt` = 0.
- Flush: queue 3 entries with `out_ready` = 0, assert `flush` together with `in_valid` for 1 cycle → `level` = 0 and `out_valid` = 0 next cycle, and the flushed-cycle request is dropped.
- Async reset: assert `rst` = 0 mid-stream between clock edges → outputs go to their reset values immediately. After release, `level` = 0 and there is no stale `out_valid`.
